// File: rtl/comparator_tree_sort4_if.sv
// Bus bundle for the 4-wide sorting block: one unsorted set in, one sorted set out.
// The master modport is the producer/consumer side; the slave modport is the sorter.
interface comparator_tree_sort4_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] din1;
    logic [WIDTH-1:0] din2;
    logic [WIDTH-1:0] din3;
    logic [WIDTH-1:0] din4;
    logic             out_valid;
    logic [WIDTH-1:0] dout1;
    logic [WIDTH-1:0] dout2;
    logic [WIDTH-1:0] dout3;
    logic [WIDTH-1:0] dout4;

    modport master (
        output in_valid, din1, din2, din3, din4,
        input  out_valid, dout1, dout2, dout3, dout4
    );

    modport slave (
        input  in_valid, din1, din2, din3, din4,
        output out_valid, dout1, dout2, dout3, dout4
    );
endinterface

// File: rtl/comparator_tree_sort4.sv
// Four-input bitonic sorting network, three register stages, one set per clock.
// Data registers load every cycle; only the valid chain carries meaning.
module comparator_tree_sort4 #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    comparator_tree_sort4_if.slave bus
);

    logic [WIDTH-1:0] din_vec [4];
    logic [WIDTH-1:0] s1_next [4];
    logic [WIDTH-1:0] s1_reg  [4];
    logic [WIDTH-1:0] s2_next [4];
    logic [WIDTH-1:0] s2_reg  [4];
    logic [WIDTH-1:0] s3_next [4];
    logic [WIDTH-1:0] s3_reg  [4];
    logic [2:0]       valid_reg;

    assign din_vec[0] = bus.din1;
    assign din_vec[1] = bus.din2;
    assign din_vec[2] = bus.din3;
    assign din_vec[3] = bus.din4;

    // Each generate pass builds one compare-exchange per stage. Stage 1 sorts
    // the first pair ascending and the second descending, forming a bitonic
    // sequence that stages 2 and 3 merge. Equal words never swap.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ce
            localparam int A1 = 2 * gi;
            localparam int B1 = 2 * gi + 1;
            localparam bit UP1 = (gi == 0);
            localparam int A2 = gi;
            localparam int B2 = gi + 2;
            localparam int A3 = 2 * gi;
            localparam int B3 = 2 * gi + 1;

            logic swap1;
            logic swap2;
            logic swap3;

            assign swap1 = UP1 ? (din_vec[A1] > din_vec[B1])
                               : (din_vec[A1] < din_vec[B1]);
            assign s1_next[A1] = swap1 ? din_vec[B1] : din_vec[A1];
            assign s1_next[B1] = swap1 ? din_vec[A1] : din_vec[B1];

            assign swap2 = s1_reg[A2] > s1_reg[B2];
            assign s2_next[A2] = swap2 ? s1_reg[B2] : s1_reg[A2];
            assign s2_next[B2] = swap2 ? s1_reg[A2] : s1_reg[B2];

            assign swap3 = s2_reg[A3] > s2_reg[B3];
            assign s3_next[A3] = swap3 ? s2_reg[B3] : s2_reg[A3];
            assign s3_next[B3] = swap3 ? s2_reg[A3] : s2_reg[B3];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                s1_reg[i] <= '0;
                s2_reg[i] <= '0;
                s3_reg[i] <= '0;
            end
            valid_reg <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                s1_reg[i] <= s1_next[i];
                s2_reg[i] <= s2_next[i];
                s3_reg[i] <= s3_next[i];
            end
            valid_reg <= {valid_reg[1:0], bus.in_valid};
        end
    end

    assign bus.out_valid = valid_reg[2];
    assign bus.dout1     = s3_reg[0];
    assign bus.dout2     = s3_reg[1];
    assign bus.dout3     = s3_reg[2];
    assign bus.dout4     = s3_reg[3];

endmodule

// File: tb/tb_comparator_tree_sort4.sv
// Randomised and directed bench for comparator_tree_sort4; expected values come
// from a per-edge input history and a plain sort of the set sampled two edges back.
module tb_comparator_tree_sort4;
    localparam int W = 32;
    localparam int MAX_EDGES = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    comparator_tree_sort4_if #(.WIDTH(W)) bus_if ();

    comparator_tree_sort4 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int total = 0;
    int bad   = 0;
    int n_edges = 0;

    logic [W-1:0] h_din [MAX_EDGES][4];
    bit           h_v   [MAX_EDGES];
    bit           h_rst [MAX_EDGES];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected state just after edge n: any reset in the last three edges
    // flushes the whole pipeline; otherwise the outputs are the sorted set
    // sampled at edge n-2 and out_valid is that edge's in_valid.
    task automatic expect_after(input int n);
        logic [W-1:0] s [4];
        logic [W-1:0] t;
        bit exp_v;
        bit zap;
        zap = 1'b0;
        for (int k = n - 2; k <= n; k++) begin
            if (k < 0 || h_rst[k]) zap = 1'b1;
        end
        if (zap) begin
            for (int i = 0; i < 4; i++) s[i] = '0;
            exp_v = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) s[i] = h_din[n-2][i];
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3 - i; j++)
                    if (s[j] > s[j+1]) begin
                        t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                    end
            exp_v = h_v[n-2];
        end
        check($sformatf("out_valid@%0d", n), {{(W-1){1'b0}}, bus_if.out_valid}, {{(W-1){1'b0}}, exp_v});
        check($sformatf("dout1@%0d", n), bus_if.dout1, s[0]);
        check($sformatf("dout2@%0d", n), bus_if.dout2, s[1]);
        check($sformatf("dout3@%0d", n), bus_if.dout3, s[2]);
        check($sformatf("dout4@%0d", n), bus_if.dout4, s[3]);
        if (exp_v)
            $display("edge %0d: out=(%h %h %h %h) exp=(%h %h %h %h)", n,
                     bus_if.dout1, bus_if.dout2, bus_if.dout3, bus_if.dout4,
                     s[0], s[1], s[2], s[3]);
    endtask

    task automatic cycle(input bit r, input bit v,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d);
        rst = r;
        bus_if.in_valid = v;
        bus_if.din1 = a;
        bus_if.din2 = b;
        bus_if.din3 = c;
        bus_if.din4 = d;
        @(posedge clk);
        h_rst[n_edges] = r;
        h_v[n_edges] = v;
        h_din[n_edges][0] = a;
        h_din[n_edges][1] = b;
        h_din[n_edges][2] = c;
        h_din[n_edges][3] = d;
        n_edges++;
        @(negedge clk);
        expect_after(n_edges - 1);
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++)
            cycle(1'b0, 1'b0, $urandom, $urandom, $urandom, $urandom);
    endtask

    function automatic logic [W-1:0] rnd_word();
        case ($urandom_range(0, 4))
            0:       rnd_word = '0;
            1:       rnd_word = '1;
            2:       rnd_word = W'($urandom_range(0, 3));
            default: rnd_word = $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        bus_if.in_valid = 1'b0;
        bus_if.din1 = '0;
        bus_if.din2 = '0;
        bus_if.din3 = '0;
        bus_if.din4 = '0;

        // Reset held for two edges with live inputs, then release.
        cycle(1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom);
        cycle(1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom);
        cycle(1'b0, 1'b1, 32'd10, 32'd40, 32'd30, 32'd20);
        idle(3);

        // Reverse order.
        cycle(1'b0, 1'b1, 32'd4, 32'd3, 32'd2, 32'd1);
        idle(3);

        // Unsigned compare with duplicates.
        cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h0);
        idle(3);

        // Back-to-back streaming.
        cycle(1'b0, 1'b1, 32'd9, 32'd7, 32'd5, 32'd3);
        cycle(1'b0, 1'b1, 32'd1, 32'd1, 32'd1, 32'd1);
        cycle(1'b0, 1'b1, 32'd2, 32'd8, 32'd6, 32'd4);
        idle(3);

        // Valid gap pattern 1,0,1.
        cycle(1'b0, 1'b1, 32'd5, 32'd6, 32'd7, 32'd8);
        cycle(1'b0, 1'b0, 32'd99, 32'd98, 32'd97, 32'd96);
        cycle(1'b0, 1'b1, 32'd8, 32'd7, 32'd6, 32'd5);
        idle(3);

        // Mid-flight reset discards two in-flight sets.
        cycle(1'b0, 1'b1, 32'd11, 32'd22, 32'd33, 32'd44);
        cycle(1'b0, 1'b1, 32'd44, 32'd33, 32'd22, 32'd11);
        cycle(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        idle(4);

        // All-equal, all-zero, all-ones.
        cycle(1'b0, 1'b1, 32'd7, 32'd7, 32'd7, 32'd7);
        cycle(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle(3);

        // Random streaming with occasional resets and valid gaps.
        for (int i = 0; i < 150; i++) begin
            cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                  rnd_word(), rnd_word(), rnd_word(), rnd_word());
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout got=%0d exp=%0d", n_edges, 0);
        $fatal(1, "timeout");
    end
endmodule
